// File: rtl/run_ctrl_pkg.sv
// Shared run-control definitions for the CPU sequencer and board-level decode.
// Latency: n/a (types only).
// Backpressure: n/a.
// Exports run_state_t so LED/hex logic can decode cpu_run_ctrl.state directly.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_IDLE  = 2'd1,
    S_RUN   = 2'd2,
    S_BREAK = 2'd3
  } run_state_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider emitting a one-cycle tick every DIV enabled cycles.
// Latency: tick is combinational from the count; first tick DIV-1 enabled edges after clear.
// Backpressure: none; clr forces the count to zero and suppresses tick.
// Ports: clk, rst (async high), clr (sync clear), en (count enable), tick (terminal count).
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Terminal-count cycle; the consumer acts on the edge that ends it.
  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: CPU reset sequence, single-step, paced free-run, PC breakpoint.
// Latency: all outputs registered; step request -> cpu_ce on the next edge.
// Backpressure: none; requests not legal in the current state are dropped.
// Ports: clk/rst system clock and async reset; reset_req/step_req one-cycle pulses;
//        run_en/bp_en levels; bp_addr/pc breakpoint compare; cpu_ce/cpu_rst to the core;
//        state/bp_hit/instr_count for debug display.
module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int TICK_DIV     = 50_000_000,
  parameter int RESET_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reset_req,
  input  logic             step_req,
  input  logic             run_en,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  output logic             cpu_ce,
  output logic             cpu_rst,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] instr_count
);

  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RW-1:0] RCNT_INIT = RW'(RESET_CYCLES - 1);

  run_state_t  st;
  logic [RW-1:0] rcnt;
  logic        div_en;
  logic        div_clr;
  logic        tick;
  logic        bp_match;

  assign state = st;

  // The divider only runs while we stay in S_RUN; any exit or reset request
  // zeroes it so the next run entry starts a full TICK_DIV period.
  assign div_en  = (st == S_RUN);
  assign div_clr = reset_req || (st != S_RUN) || !run_en;

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .en   (div_en),
    .tick (tick)
  );

  // pc is stable between enables, so comparing it in the terminal-count
  // cycle tests the instruction that would execute next.
  assign bp_match = bp_en && (pc == bp_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= S_RST;
      rcnt        <= RCNT_INIT;
      cpu_rst     <= 1'b1;
      cpu_ce      <= 1'b0;
      bp_hit      <= 1'b0;
      instr_count <= '0;
    end else begin
      cpu_ce <= 1'b0;
      if (reset_req) begin
        st          <= S_RST;
        rcnt        <= RCNT_INIT;
        cpu_rst     <= 1'b1;
        bp_hit      <= 1'b0;
        instr_count <= '0;
      end else begin
        case (st)
          S_RST: begin
            if (rcnt == '0) begin
              st      <= S_IDLE;
              cpu_rst <= 1'b0;
            end else begin
              rcnt <= rcnt - 1'b1;
            end
          end
          S_IDLE: begin
            if (run_en) begin
              st <= S_RUN;
            end else if (step_req) begin
              cpu_ce      <= 1'b1;
              bp_hit      <= 1'b0;
              instr_count <= instr_count + 1'b1;
            end
          end
          S_RUN: begin
            if (!run_en) begin
              st <= S_IDLE;
            end else if (tick) begin
              if (bp_match) begin
                // Halt before the instruction at bp_addr executes.
                st     <= S_BREAK;
                bp_hit <= 1'b1;
              end else begin
                cpu_ce      <= 1'b1;
                bp_hit      <= 1'b0;
                instr_count <= instr_count + 1'b1;
              end
            end
          end
          S_BREAK: begin
            // Step past the breakpoint, or abandon the run; both land in
            // S_IDLE so a resume always re-arms the divider from zero.
            if (step_req) begin
              st          <= S_IDLE;
              cpu_ce      <= 1'b1;
              bp_hit      <= 1'b0;
              instr_count <= instr_count + 1'b1;
            end else if (!run_en) begin
              st <= S_IDLE;
            end
          end
          default: begin
            st <= S_RST;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with an enable scoreboard (expected cycle and count per cpu_ce).
// Latency: n/a.
// Backpressure: n/a.
module tb_cpu_run_ctrl;
  import run_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        reset_req;
  logic        step_req;
  logic        run_en;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        cpu_ce;
  logic        cpu_rst;
  logic [1:0]  state;
  logic        bp_hit;
  logic [31:0] instr_count;

  cpu_run_ctrl #(
    .TICK_DIV     (4),
    .RESET_CYCLES (3),
    .CNT_W        (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .reset_req   (reset_req),
    .step_req    (step_req),
    .run_en      (run_en),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .pc          (pc),
    .cpu_ce      (cpu_ce),
    .cpu_rst     (cpu_rst),
    .state       (state),
    .bp_hit      (bp_hit),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   k;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_chk++;
    assert (obs === want)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic push(input int c, input int n);
    exp_t e;
    e.cyc = c;
    e.cnt = n;
    q.push_back(e);
  endtask

  // One clock: sample 1 ns after the edge, then match any enable against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    chk("ce_rst_excl", {63'd0, cpu_ce & cpu_rst}, 64'd0);
    if (cpu_ce === 1'b1) begin
      pc = pc + 32'd4;
      if (q.size() == 0) begin
        chk("ce_unexpected", {63'd0, cpu_ce}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("ce_cycle", 64'(cyc), 64'(e.cyc));
        chk("ce_count", 64'(instr_count), 64'(e.cnt));
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      chk("ce_missing", {63'd0, cpu_ce}, 64'd1);
      e = q.pop_front();
    end
  endtask

  initial begin
    rst       = 1'b1;
    reset_req = 1'b0;
    step_req  = 1'b0;
    run_en    = 1'b0;
    bp_en     = 1'b0;
    bp_addr   = 32'd0;
    pc        = 32'd0;

    tick();
    tick();
    chk("rst_state", 64'(state), 64'(S_RST));
    chk("rst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    chk("rst_cpu_ce", {63'd0, cpu_ce}, 64'd0);
    chk("rst_bp_hit", {63'd0, bp_hit}, 64'd0);
    chk("rst_count", 64'(instr_count), 64'd0);

    // Reset sequence: cpu_rst held for three edges after release.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("seq_cpu_rst", {63'd0, cpu_rst}, (i < 2) ? 64'd1 : 64'd0);
      chk("seq_state", 64'(state), (i < 2) ? 64'(S_RST) : 64'(S_IDLE));
    end
    chk("idle_count", 64'(instr_count), 64'd0);
    chk("idle_ce", {63'd0, cpu_ce}, 64'd0);

    // Three single steps, each enable one cycle after its request.
    for (int i = 0; i < 3; i++) begin
      step_req = 1'b1;
      push(cyc + 1, i + 1);
      tick();
      step_req = 1'b0;
      tick();
    end
    chk("step_count", 64'(instr_count), 64'd3);
    chk("step_sb_empty", 64'(q.size()), 64'd0);

    // Run until four more enables (count 7), then reset on a terminal-count cycle.
    run_en = 1'b1;
    k = cyc + 1;
    for (int j = 1; j <= 4; j++) push(k + 4 * j, 3 + j);
    repeat (20) tick();
    chk("run1_count", 64'(instr_count), 64'd7);
    chk("run1_state", 64'(state), 64'(S_RUN));
    reset_req = 1'b1;
    tick();
    reset_req = 1'b0;
    chk("rreq_ce", {63'd0, cpu_ce}, 64'd0);
    chk("rreq_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    chk("rreq_count", 64'(instr_count), 64'd0);
    chk("rreq_state", 64'(state), 64'(S_RST));
    tick();
    tick();
    chk("rreq_hold", {63'd0, cpu_rst}, 64'd1);
    tick();
    chk("rreq_release", {63'd0, cpu_rst}, 64'd0);
    chk("rreq_idle", 64'(state), 64'(S_IDLE));
    tick();
    chk("rreq_rerun", 64'(state), 64'(S_RUN));

    // Free run: five enables every 4th cycle, then drop run_en on a terminal count.
    k = cyc;
    for (int j = 1; j <= 5; j++) push(k + 4 * j, j);
    repeat (23) tick();
    chk("run2_count", 64'(instr_count), 64'd5);
    run_en = 1'b0;
    tick();
    chk("drop_ce", {63'd0, cpu_ce}, 64'd0);
    chk("drop_state", 64'(state), 64'(S_IDLE));
    chk("drop_count", 64'(instr_count), 64'd5);
    chk("run2_sb_empty", 64'(q.size()), 64'd0);

    // Breakpoint at 0x10 with pc advancing by 4 per enable from 0.
    bp_en   = 1'b1;
    bp_addr = 32'h10;
    pc      = 32'd0;
    run_en  = 1'b1;
    k = cyc + 1;
    for (int j = 1; j <= 4; j++) push(k + 4 * j, 5 + j);
    repeat (21) tick();
    chk("bp_state", 64'(state), 64'(S_BREAK));
    chk("bp_hit", {63'd0, bp_hit}, 64'd1);
    chk("bp_ce", {63'd0, cpu_ce}, 64'd0);
    chk("bp_count", 64'(instr_count), 64'd9);
    repeat (3) tick();
    chk("bp_stay", 64'(state), 64'(S_BREAK));
    step_req = 1'b1;
    push(cyc + 1, 10);
    tick();
    step_req = 1'b0;
    run_en   = 1'b0;
    chk("bp_step_ce", {63'd0, cpu_ce}, 64'd1);
    chk("bp_step_hit", {63'd0, bp_hit}, 64'd0);
    chk("bp_step_state", 64'(state), 64'(S_IDLE));
    tick();
    chk("bp_idle", 64'(state), 64'(S_IDLE));

    // Reset request beats a simultaneous step.
    reset_req = 1'b1;
    step_req  = 1'b1;
    tick();
    reset_req = 1'b0;
    step_req  = 1'b0;
    chk("rs_ce", {63'd0, cpu_ce}, 64'd0);
    chk("rs_state", 64'(state), 64'(S_RST));
    chk("rs_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    chk("rs_count", 64'(instr_count), 64'd0);
    repeat (3) tick();
    chk("rs_idle", 64'(state), 64'(S_IDLE));
    chk("final_sb_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run-control sequencer for the single-cycle RV32I core on the DE-board top level. Replaces the gated/derived CPU clock with a single-cycle clock-enable (`cpu_ce`) on the 50 MHz system clock. Generates the CPU reset sequence, manual single-step, free-run at a programmable rate, and a PC breakpoint halt, and exposes an instruction counter for the 7-segment debug mux. Inputs `step_req`/`reset_req` come from the existing debouncer + edge_detector chain as one-cycle pulses.

## Interface
Parameters:
- `TICK_DIV`, 50_000_000, system cycles between automatic instruction enables in run mode (≥2)
- `RESET_CYCLES`, 4, number of cycles `cpu_rst` is held high per reset sequence (≥1)
- `CNT_W`, 32, width of `instr_count`

Ports:
- `clk`  in  1  system clock; the only clock
- `rst`  in  1  asynchronous, active-high reset
- `reset_req`  in  1  one-cycle pulse: restart CPU reset sequence
- `step_req`  in  1  one-cycle pulse: execute one instruction when halted
- `run_en`  in  1  level: free-run mode
- `bp_en`  in  1  level: breakpoint enable
- `bp_addr`  in  32  breakpoint PC
- `pc`  in  32  current CPU PC (stable between enables)
- `cpu_ce`  out  1  one-cycle instruction enable to CPU state elements
- `cpu_rst`  out  1  CPU reset
- `state`  out  2  current FSM state (for LEDs)
- `bp_hit`  out  1  sticky: halted on breakpoint
- `instr_count`  out  CNT_W  number of `cpu_ce` pulses since last reset sequence

## Operation
- All outputs registered. `rst` values: `state`=S_RST, `cpu_rst`=1, `cpu_ce`=0, `bp_hit`=0, `instr_count`=0, divider=0, reset counter=RESET_CYCLES-1.
- States: S_RST, S_IDLE, S_RUN, S_BREAK.
- Priority in every state: `reset_req` first → S_RST, reload reset counter, clear `instr_count`, `bp_hit`, divider; no `cpu_ce`.
- S_RST: `cpu_rst`=1; counter decrements; at 0 → S_IDLE. `cpu_rst` high exactly RESET_CYCLES cycles.
- S_IDLE: `run_en`=1 → S_RUN, divider cleared. Else `step_req`=1 → `cpu_ce` pulse, stay S_IDLE. Breakpoint ignored for explicit steps.
- S_RUN: divider counts 0..TICK_DIV-1, wraps to 0. At terminal count: if `bp_en` && `pc`==`bp_addr` → S_BREAK, `bp_hit`=1, no `cpu_ce` (instruction at bp_addr not executed); else `cpu_ce` pulse. `run_en`=0 → S_IDLE, divider cleared, pending tick dropped. `step_req` ignored.
- S_BREAK: no enables. `step_req` → `cpu_ce` pulse, → S_IDLE. `run_en`=0 → S_IDLE, `bp_hit` kept. Resume requires passing through S_IDLE.
- `bp_hit` clears on any `cpu_ce` or reset sequence.
- `instr_count` increments on the same edge `cpu_ce` is set; wraps modulo 2^CNT_W.
- Invariant: `cpu_ce` and `cpu_rst` never both high; `cpu_ce` never high two consecutive cycles in S_RUN.

## Timing
- `step_req` sampled high at edge k (S_IDLE/S_BREAK) → `cpu_ce`=1 from edge k to edge k+1.
- Entering S_RUN at edge k → first `cpu_ce` at edge k+TICK_DIV, then every TICK_DIV cycles.
- Breakpoint compare uses `pc` combinationally in the terminal-count cycle; `pc` changes only after a `cpu_ce`.
- `reset_req` at edge k → `cpu_rst` high edges k..k+RESET_CYCLES, S_IDLE at edge k+RESET_CYCLES.
- Simultaneous: `reset_req` beats everything; `run_en` drop beats tick; `run_en`=1 beats `step_req` in S_IDLE.

## Structure
- Package `run_ctrl_pkg`: `run_state_t` enum {S_RST=2'd0, S_IDLE=2'd1, S_RUN=2'd2, S_BREAK=2'd3}; exported so top-level LED/hex logic decodes `state`.
- Sub-module `tick_gen` (parameter DIV; ports clk, rst, clr, en, tick): divider producing one-cycle `tick`, cleared by `clr`.
- FSM, reset counter, breakpoint compare and instruction counter in `cpu_run_ctrl`.

## Test plan
(TICK_DIV=4, RESET_CYCLES=3)
- Deassert `rst` → `cpu_rst` high 3 cycles after `rst` falls, then `state`=S_IDLE, `cpu_ce`=0, `instr_count`=0.
- Three `step_req` pulses in S_IDLE → three single-cycle `cpu_ce`, each 1 cycle after request; `instr_count`=3.
- `run_en`=1 for 20 cycles → `cpu_ce` every 4th cycle, 5 pulses, first 4 cycles after entry; drop `run_en` on a terminal-count cycle → no pulse, S_IDLE.
- `bp_en`=1, `bp_addr`=0x10, `pc` model advances by 4 per `cpu_ce` from 0 → 4 enables then S_BREAK, `bp_hit`=1, `pc`=0x10; `step_req` → 1 `cpu_ce`, `bp_hit`=0, S_IDLE.
- `reset_req` mid-run with `instr_count`=7 → same-cycle no `cpu_ce`, `cpu_rst` 3 cycles, `instr_count`=0, S_IDLE even with `run_en` held (re-enters S_RUN next cycle).
- `reset_req` and `step_req` in same cycle → no `cpu_ce`; reset sequence only.
